fp32_division: RTL and testbench

Iterative IEEE-754 single-precision divider computing s = a / b. Used as the divide unit of the floating-point arithmetic block. A start pulse launches a fixed-latency, multi-cycle operation. A done pulse returns the packed result with exception flags. Mantissas use a restoring radix-2 shift/subtract loop, so no hard divider is needed.

---
 rtl/fp32_division_pkg.sv | 30 +++
 rtl/fp32_division_if.sv | 16 +
 rtl/fp32_unpack.sv | 22 ++
 rtl/fp32_division.sv | 177 +++++++++++++++++
 tb/tb_fp32_division.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_division_pkg.sv
// Shared widths, encodings, FSM state codes and the unpacked-operand record for the fp32 divider.
package fp32_division_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned ITER_N = 26;
  localparam int unsigned MANT_W = FRAC_W + 1;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [30:0] INF_MAG  = 31'h7F80_0000;
  localparam logic [30:0] ZERO_MAG = 31'h0000_0000;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StUnpack = 2'd1;
  localparam logic [1:0] StIter   = 2'd2;
  localparam logic [1:0] StRound  = 2'd3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } operand_t;

endpackage

// File: rtl/fp32_division_if.sv
// Start/operand/result bundle between the FP arithmetic block and the divider.
interface fp32_division_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] s;
  logic        busy;
  logic        done;
  logic        dz;
  logic        nv;
  logic        of;
  logic        uf;

  modport master (output start, a, b, input s, busy, done, dz, nv, of, uf);
  modport slave  (input start, a, b, output s, busy, done, dz, nv, of, uf);
endinterface

// File: rtl/fp32_unpack.sv
// Splits a binary32 word into fields and classifies it; subnormals classify as zero.
module fp32_unpack
  import fp32_division_pkg::*;
(
  input  logic [31:0] value_i,
  output operand_t    op_o
);
  logic [EXP_W-1:0]  exp;
  logic [FRAC_W-1:0] frac;

  assign exp  = value_i[30:23];
  assign frac = value_i[22:0];

  always_comb begin
    op_o.sign    = value_i[31];
    op_o.exp     = exp;
    op_o.mant    = {1'b1, frac};
    op_o.is_zero = (exp == '0);
    op_o.is_inf  = (exp == '1) && (frac == '0);
    op_o.is_nan  = (exp == '1) && (frac != '0);
  end
endmodule

// File: rtl/fp32_division.sv
// Iterative binary32 divider: restoring radix-2 mantissa loop, RNE rounding, fixed 28-cycle latency.
module fp32_division
  import fp32_division_pkg::*;
(
  input logic           clk,
  input logic           rst,
  fp32_division_if.slave bus
);
  logic [1:0]         state_q, state_d;
  logic [31:0]        a_q, b_q;
  operand_t           op_a, op_b;
  logic [4:0]         iter_cnt_q;
  logic [MANT_W:0]    rem_q;
  logic [ITER_N-1:0]  quo_q;
  logic [MANT_W-1:0]  mb_q;
  logic signed [9:0]  exp_q;
  logic               sign_q;
  logic               special_q, spec_nv_q, spec_dz_q;
  logic [31:0]        spec_res_q;
  logic [31:0]        s_q;
  logic               done_q, dz_q, nv_q, of_q, uf_q;
  logic               accept, sign_ab;

  fp32_unpack u_unpack_a (.value_i(a_q), .op_o(op_a));
  fp32_unpack u_unpack_b (.value_i(b_q), .op_o(op_b));

  // Start is honoured in the done cycle too, since the FSM is already back in idle.
  assign accept  = (state_q == StIdle) && bus.start;
  assign sign_ab = op_a.sign ^ op_b.sign;

  assign bus.s    = s_q;
  assign bus.busy = (state_q != StIdle) || done_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.nv   = nv_q;
  assign bus.of   = of_q;
  assign bus.uf   = uf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StUnpack;
      StUnpack: state_d = StIter;
      StIter:   if (iter_cnt_q == 5'(ITER_N - 1)) state_d = StRound;
      StRound:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  logic            spec_d, spec_nv_d, spec_dz_d;
  logic [31:0]     spec_res_d;

  always_comb begin
    spec_d     = 1'b1;
    spec_nv_d  = 1'b0;
    spec_dz_d  = 1'b0;
    spec_res_d = POS_ZERO;
    if (op_a.is_nan || op_b.is_nan || (op_a.is_zero && op_b.is_zero) ||
        (op_a.is_inf && op_b.is_inf)) begin
      spec_res_d = QNAN;
      spec_nv_d  = 1'b1;
    end else if (op_a.is_inf) begin
      spec_res_d = {sign_ab, INF_MAG};
    end else if (op_b.is_inf) begin
      spec_res_d = {sign_ab, ZERO_MAG};
    end else if (op_b.is_zero) begin
      spec_res_d = {sign_ab, INF_MAG};
      spec_dz_d  = 1'b1;
    end else if (op_a.is_zero) begin
      spec_res_d = {sign_ab, ZERO_MAG};
    end else begin
      spec_d = 1'b0;
    end
  end

  logic            ge;
  logic [MANT_W:0] rem_step;

  assign ge       = rem_q >= {1'b0, mb_q};
  assign rem_step = ge ? rem_q - {1'b0, mb_q} : rem_q;

  logic              norm, guard, sticky, round_up, round_of, round_uf;
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W:0]   frac_r;
  logic signed [9:0] exp_n, exp_r;
  logic [31:0]       round_res;

  // Quotient is in (0.5, 2): bit 25 set means integer part 1, otherwise bit 24 is the leading one.
  always_comb begin
    norm     = quo_q[ITER_N-1];
    frac     = norm ? quo_q[ITER_N-2 -: FRAC_W] : quo_q[ITER_N-3 -: FRAC_W];
    guard    = norm ? quo_q[1] : quo_q[0];
    sticky   = (norm & quo_q[0]) | (|rem_q);
    exp_n    = norm ? exp_q : exp_q - 10'sd1;
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
    exp_r    = frac_r[FRAC_W] ? exp_n + 10'sd1 : exp_n;
    round_of = exp_r >= 10'sd255;
    round_uf = exp_r <= 10'sd0;
    if (round_of) begin
      round_res = {sign_q, INF_MAG};
    end else if (round_uf) begin
      round_res = {sign_q, ZERO_MAG};
    end else begin
      round_res = {sign_q, exp_r[7:0], frac_r[FRAC_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      iter_cnt_q <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      mb_q       <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_nv_q  <= 1'b0;
      spec_dz_q  <= 1'b0;
      spec_res_q <= '0;
      s_q        <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      nv_q       <= 1'b0;
      of_q       <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            dz_q <= 1'b0;
            nv_q <= 1'b0;
            of_q <= 1'b0;
            uf_q <= 1'b0;
          end
        end
        StUnpack: begin
          exp_q      <= $signed({2'b00, op_a.exp}) - $signed({2'b00, op_b.exp}) + 10'sd127;
          rem_q      <= {1'b0, op_a.mant};
          mb_q       <= op_b.mant;
          quo_q      <= '0;
          iter_cnt_q <= '0;
          sign_q     <= sign_ab;
          special_q  <= spec_d;
          spec_nv_q  <= spec_nv_d;
          spec_dz_q  <= spec_dz_d;
          spec_res_q <= spec_res_d;
        end
        StIter: begin
          rem_q      <= {rem_step[MANT_W-1:0], 1'b0};
          quo_q      <= {quo_q[ITER_N-2:0], ge};
          iter_cnt_q <= iter_cnt_q + 5'd1;
        end
        StRound: begin
          done_q <= 1'b1;
          if (special_q) begin
            s_q  <= spec_res_q;
            nv_q <= spec_nv_q;
            dz_q <= spec_dz_q;
          end else begin
            s_q  <= round_res;
            of_q <= round_of;
            uf_q <= round_uf;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_division.sv
// Scoreboard bench for fp32_division: directed vectors, control corner cases, randomized ops vs model.
module tb_fp32_division;
  import fp32_division_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  fp32_division_if bus();
  fp32_division dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [3:0]  flags;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer quotient, then round-to-nearest-even; flags packed {dz,nv,of,uf}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic sign;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    logic [63:0] num, den, q, r, sig, rest, half;
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    sign = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    nan_a = (ea == 255) && (fa != 0);
    nan_b = (eb == 255) && (fb != 0);
    inf_a = (ea == 255) && (fa == 0);
    inf_b = (eb == 255) && (fb == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) return {4'b0100, 32'h7FC00000};
    if (inf_a) return {4'b0000, sign, 31'h7F800000};
    if (inf_b) return {4'b0000, sign, 31'd0};
    if (zero_b) return {4'b1000, sign, 31'h7F800000};
    if (zero_a) return {4'b0000, sign, 31'd0};
    num = {1'b1, fa, 40'd0};
    den = {40'd0, 1'b1, fb};
    q = num / den;
    r = num % den;
    e = ea - eb + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin
      sh = 16;
      e = e - 1;
    end
    sig = q >> sh;
    rest = q & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rest > half || (rest == half && (r != 0 || sig[0]))) sig = sig + 64'd1;
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {4'b0010, sign, 31'h7F800000};
    if (e <= 0) return {4'b0001, sign, 31'd0};
    return {4'b0000, sign, e[7:0], sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int unsigned k;
    logic [31:0] v;
    k = $urandom_range(0, 9);
    v = $urandom();
    case (k)
      0: ;
      1: begin
        case ($urandom_range(0, 4))
          0: v = {v[31], 31'd0};
          1: v = {v[31], 8'hFF, 23'd0};
          2: v = {v[31], 8'hFF, v[22:1], 1'b1};
          3: v = {v[31], 8'd0, v[22:0]};
          default: v = {v[31], 8'd1, v[22:0]};
        endcase
      end
      2: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got s=%h, expected no done pulse", bus.s);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("s[%h/%h]", mon_e.a, mon_e.b), bus.s, mon_e.s);
        check($sformatf("flags[%h/%h]", mon_e.a, mon_e.b),
              {28'd0, bus.dz, bus.nv, bus.of, bus.uf}, {28'd0, mon_e.flags});
        check($sformatf("latency[%h/%h]", mon_e.a, mon_e.b), cyc - mon_e.cyc, 32'd28);
        check("busy_in_done", {31'd0, bus.busy}, 32'd1);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic push,
                      input logic [31:0] s_exp, input logic [3:0] f_exp);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom();
    bus.b = $urandom();
    if (push) sb.push_back('{a: a, b: b, s: s_exp, flags: f_exp, cyc: cyc});
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got busy=%b, expected 0 within 100 cycles", bus.busy);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s_exp, input logic [3:0] f_exp);
    wait_idle();
    send(a, b, 1'b1, s_exp, f_exp);
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
    logic [35:0] m;
    m = model(a, b);
    issue(a, b, m[31:0], m[35:32]);
  endtask

  localparam int NDIR = 17;
  logic [31:0] ta[NDIR] = '{32'h43D10000, 32'h43800000, 32'h3F000000, 32'h3F000000,
                            32'hC0C00000, 32'hC0C00000, 32'h00000000, 32'h3F800000,
                            32'h7F800000, 32'h00000000, 32'h7F000000, 32'h00800000,
                            32'h7F800000, 32'h40000000, 32'h7FC00001, 32'h00000001,
                            32'h3F800000};
  logic [31:0] tbv[NDIR] = '{32'h40000000, 32'h42F00000, 32'h41100000, 32'h3E000000,
                             32'h74800000, 32'h1F800000, 32'h00000000, 32'h00000000,
                             32'h7F800000, 32'h40000000, 32'h00800000, 32'h4F800000,
                             32'h40000000, 32'hFF800000, 32'h3F800000, 32'h3F800000,
                             32'h80000001};
  logic [31:0] ts[NDIR] = '{32'h43510000, 32'h40088889, 32'h3D638E39, 32'h40800000,
                            32'h8BC00000, 32'hE0C00000, 32'h7FC00000, 32'h7F800000,
                            32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000,
                            32'h7F800000, 32'h80000000, 32'h7FC00000, 32'h00000000,
                            32'hFF800000};
  logic [3:0] tf[NDIR] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                           4'b0100, 4'b1000, 4'b0100, 4'b0000, 4'b0010, 4'b0001,
                           4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1000};

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [35:0] m;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_s", bus.s, 32'd0);
    check("reset_ctl", {30'd0, bus.busy, bus.done}, 32'd0);
    check("reset_flags", {28'd0, bus.dz, bus.nv, bus.of, bus.uf}, 32'd0);

    for (int i = 0; i < NDIR; i++) issue(ta[i], tbv[i], ts[i], tf[i]);

    // Starts while busy must be dropped.
    issue_model(32'h40400000, 32'h3FC00000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy_during_op", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b1;
      bus.a = $urandom();
      bus.b = $urandom();
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (35) @(negedge clk);

    // Reset around iteration 10 aborts with no done pulse.
    wait_idle();
    send(32'h3F800000, 32'h40400000, 1'b0, 32'd0, 4'd0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_s", bus.s, 32'd0);
    check("abort_ctl", {30'd0, bus.busy, bus.done}, 32'd0);
    check("abort_flags", {28'd0, bus.dz, bus.nv, bus.of, bus.uf}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Back-to-back start in the done cycle.
    issue_model(32'h40A00000, 32'h40000000);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.done !== 1'b1 && k < 40);
    if (bus.done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL b2b_done_wait: got done=%b, expected 1 within 40 cycles", bus.done);
    end
    m = model(32'h42C80000, 32'h41200000);
    send(32'h42C80000, 32'h41200000, 1'b1, m[31:0], m[35:32]);

    for (int i = 0; i < 200; i++) issue_model(rand_op(), rand_op());

    wait_idle();
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
